// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the three-register ALU datapath: buffers host commands in
// a FIFO, drives the datapath control pins one command at a time, returns READ results.
module alu_cmd_sequencer #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_reg,
  input  logic [2:0]       cmd_alu_op,
  input  logic             cmd_cin,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_flags,
  output logic [WIDTH-1:0] dp_data_in,
  output logic [1:0]       dp_reg_sel,
  output logic [2:0]       dp_alu_op,
  output logic             dp_write_en,
  output logic             dp_alu_en,
  output logic             dp_cin,
  input  logic [WIDTH-1:0] dp_data_out,
  input  logic             dp_zero,
  input  logic             dp_neg,
  input  logic             dp_ovf,
  output logic             busy,
  output logic             sticky_ovf,
  output logic             sticky_err,
  input  logic             clr_sticky,
  output logic [1:0]       dbg_state
);
  // Handshakes: a command transfers on cmd_valid && cmd_ready, a response on
  // rsp_valid && rsp_ready; a raised valid holds its payload stable until the transfer.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [1:0] OP_LOAD = 2'b00, OP_EXEC = 2'b01, OP_READ = 2'b10, OP_REPEAT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_REPEAT, S_RESP} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [1:0]       rsel;
    logic [2:0]       alu_op;
    logic             cin;
    logic [WIDTH-1:0] imm;
    logic [CNT_W-1:0] cnt;
  } cmd_t;

  state_t           state, state_nxt;
  cmd_t             mem [FIFO_DEPTH];
  cmd_t             cmd_in, cmd_q;
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, push, pop;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       flags_q;
  logic             reg_ok, ovf_set, err_set;

  assign cmd_in     = {cmd_op, cmd_reg, cmd_alu_op, cmd_cin, cmd_imm, cmd_cnt};
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign busy       = (state != S_IDLE) || !fifo_empty;
  assign reg_ok     = (cmd_q.rsel != 2'd3);
  assign rsp_flags  = flags_q;
  assign dbg_state  = state;

  // Flags and overflow only count on cycles that actually write an ALU result.
  assign ovf_set = dp_write_en && dp_alu_en && dp_ovf;
  assign err_set = (state == S_ISSUE) && (cmd_q.op != OP_REPEAT) && !reg_ok;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= cmd_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!fifo_empty) state_nxt = S_ISSUE;
      S_ISSUE: begin
        case (cmd_q.op)
          OP_READ:   state_nxt = S_RESP;
          OP_REPEAT: state_nxt = (cmd_q.cnt != '0) ? S_REPEAT : S_IDLE;
          default:   state_nxt = S_IDLE;
        endcase
      end
      S_REPEAT: if (cnt_q == CNT_W'(1)) state_nxt = S_IDLE;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dp_data_in  = '0;
    dp_reg_sel  = '0;
    dp_alu_op   = '0;
    dp_write_en = 1'b0;
    dp_alu_en   = 1'b0;
    dp_cin      = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      S_ISSUE: begin
        case (cmd_q.op)
          OP_LOAD: begin
            dp_write_en = reg_ok;
            dp_reg_sel  = cmd_q.rsel;
            dp_data_in  = cmd_q.imm;
          end
          OP_EXEC: begin
            dp_write_en = reg_ok;
            dp_alu_en   = reg_ok;
            dp_reg_sel  = cmd_q.rsel;
            dp_data_in  = cmd_q.imm;
            dp_alu_op   = cmd_q.alu_op;
            dp_cin      = cmd_q.cin;
          end
          OP_READ:  dp_reg_sel = cmd_q.rsel;
          default: ;
        endcase
      end
      S_REPEAT: begin
        dp_write_en = 1'b1;
        dp_alu_en   = 1'b1;
        dp_reg_sel  = 2'd2;
        dp_data_in  = cmd_q.imm;
        dp_alu_op   = cmd_q.alu_op;
        dp_cin      = cmd_q.cin;
      end
      S_RESP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= '0;
      cnt_q      <= '0;
      flags_q    <= '0;
      rsp_data   <= '0;
      sticky_ovf <= 1'b0;
      sticky_err <= 1'b0;
    end else begin
      if (pop) cmd_q <= mem[rd_ptr[PTR_W-1:0]];
      if ((state == S_ISSUE) && (cmd_q.op == OP_REPEAT)) cnt_q <= cmd_q.cnt;
      else if (state == S_REPEAT)                        cnt_q <= cnt_q - 1'b1;
      if (dp_write_en && dp_alu_en) flags_q <= {dp_ovf, dp_neg, dp_zero};
      if ((state == S_ISSUE) && (cmd_q.op == OP_READ))
        rsp_data <= reg_ok ? dp_data_out : '0;
      sticky_ovf <= ovf_set || (sticky_ovf && !clr_sticky);
      sticky_err <= err_set || (sticky_err && !clr_sticky);
    end
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-driven controller for the three-register ALU datapath. The datapath has registers A, B and C (reg_sel 0, 1, 2). With alu_en=1 it computes ALU(data_in, C); with alu_en=0 a write stores data_in directly. This block buffers host commands in a FIFO, sequences them onto the datapath control pins (including multi-cycle REPEAT accumulation), and returns READ results with flags over a valid/ready response channel. It sits between the host/test harness and the datapath and is the only driver of the datapath control inputs.

Parameters:
WIDTH, 8, datapath word width
FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
CNT_W, 4, width of REPEAT count field

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_op  in  2  00 LOAD, 01 EXEC, 10 READ, 11 REPEAT
cmd_reg  in  2  destination/source register (0=A, 1=B, 2=C, 3=invalid)
cmd_alu_op  in  3  ALU opcode for EXEC/REPEAT
cmd_cin  in  1  carry-in for EXEC/REPEAT
cmd_imm  in  WIDTH  immediate / ALU operand a
cmd_cnt  in  CNT_W  REPEAT iteration count
rsp_valid  out  1  READ result available
rsp_ready  in  1  host accepts result
rsp_data  out  WIDTH  register value read
rsp_flags  out  3  {ovf, neg, zero} from last EXEC/REPEAT cycle
dp_data_in  out  WIDTH  to datapath data_in
dp_reg_sel  out  2  to datapath reg_sel
dp_alu_op  out  3  to datapath alu_op
dp_write_en  out  1  to datapath write_en
dp_alu_en  out  1  to datapath alu_en
dp_cin  out  1  to datapath cin
dp_data_out  in  WIDTH  datapath register read mux (combinational)
dp_zero, dp_neg, dp_ovf  in  1 each  datapath flags (combinational)
busy  out  1  FSM not IDLE or FIFO non-empty
sticky_ovf  out  1  set by any EXEC/REPEAT cycle with dp_ovf=1
sticky_err  out  1  set by any command with cmd_reg=3
clr_sticky  in  1  clears both sticky bits

Behaviour:
- Reset (async): FIFO empty, FSM IDLE, all dp_* = 0, rsp_valid=0, rsp_data=0, rsp_flags=0, sticky bits 0, cmd_ready=1 after reset release.
- cmd_ready = !fifo_full. Push on cmd_valid&&cmd_ready. A push and pop in the same cycle are both allowed; occupancy is unchanged.
- FSM states: IDLE, ISSUE, REPEAT, RESP.
- IDLE: if FIFO non-empty, pop head into the command register and go to ISSUE. While in IDLE, all dp_* outputs are 0.
- Latency: command accepted in cycle 0, popped in cycle 1, driven in cycle 2. The datapath register updates at the end of cycle 2.
- ISSUE with LOAD: drive write_en=1, alu_en=0, reg_sel=cmd_reg, data_in=imm for 1 cycle, then go to IDLE.
- ISSUE with EXEC: drive write_en=1, alu_en=1, alu_op, cin, data_in=imm, reg_sel=cmd_reg for 1 cycle. Capture {dp_ovf, dp_neg, dp_zero} into the flags register, then go to IDLE.
- ISSUE with READ: write_en=0, reg_sel=cmd_reg. Capture dp_data_out into rsp_data and go to RESP.
- ISSUE with REPEAT: load the counter with cmd_cnt. If cnt=0, go to IDLE with no write. Otherwise go to REPEAT.
- REPEAT: each cycle drives an EXEC with reg_sel=2 (C ← ALU(imm, C)) and captures flags. The counter decrements; the state exits to IDLE after cnt write cycles. cmd_reg is ignored for REPEAT.
- RESP: rsp_valid=1, with rsp_data/rsp_flags stable until rsp_ready. The transfer completes on rsp_valid&&rsp_ready, then the FSM goes to IDLE. No further command is popped while in RESP.
- cmd_reg=3 with LOAD/EXEC/READ: no write (write_en stays 0) and sticky_err sets. READ still responds, with rsp_data=0.
- dp_ovf is only considered when alu_en=1 and write_en=1.
- Sticky bits: if a set and clr_sticky occur in the same cycle, set wins.
- Commands execute strictly in FIFO order. At most one command is in flight.

Test Plan:
- LOAD C=0x05; EXEC add(000) imm=0x03 cin=0 into A; READ A -> rsp_data=0x08, rsp_flags=000; dp_write_en pulses exactly 2 cycles.
- LOAD C=0x05; REPEAT add imm=0x10 cnt=3; READ C -> rsp_data=0x35; exactly 3 consecutive write cycles with reg_sel=2.
- LOAD C=0x20; EXEC add imm=0x70 into B; READ B -> 0x90, rsp_flags=110, sticky_ovf=1. clr_sticky then pulses -> sticky_ovf=0.
- Hold rsp_ready=0 and push 1 READ followed by 5 LOADs -> cmd_ready falls after FIFO_DEPTH queued entries. Raise rsp_ready -> all LOADs drain in order.
- REPEAT cnt=0 -> no write, busy drops. LOAD to reg 3 -> no write, sticky_err=1.
- Assert rst_n=0 mid-REPEAT (cnt=8, after 3 iterations) -> dp_write_en=0 immediately, FIFO empty, rsp_valid=0, sticky bits 0.
